// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encodings, length codes, constants and
// byte-lane helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        MC_IDLE   = 2'd0,
        MC_IF_RD  = 2'd1,
        MC_MEM_RD = 2'd2,
        MC_MEM_WR = 2'd3
    } mc_state_e;

    // MEM access length codes (2'b11 is treated as a word as well)
    localparam logic [1:0] MC_LEN_B = 2'b00;
    localparam logic [1:0] MC_LEN_H = 2'b01;
    localparam logic [1:0] MC_LEN_W = 2'b10;

    // Existing codebase constants
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [7:0]  Zero8        = 8'h00;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;

    // Number of RAM byte cycles for a MEM length code
    function automatic logic [2:0] mc_len_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            MC_LEN_B: n = 3'd1;
            MC_LEN_H: n = 3'd2;
            MC_LEN_W: n = 3'd4;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

    // Extract little-endian byte lane idx of a word
    function automatic logic [7:0] mc_get_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = Zero8;
        endcase
        return b;
    endfunction

    // Replace little-endian byte lane idx of a word
    function automatic logic [31:0] mc_put_byte(input logic [31:0] word, input logic [1:0] idx,
                                                input logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (idx)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            2'd3:    w[31:24] = b;
            default: w = word;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: IF/MEM request-response signals plus the byte-wide RAM pins.
// if_flush_i exists only when MEM_CTRL_IF_ABORT_EN is defined.
interface mem_ctrl_if;

    // Instruction fetch side
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_done_o;
    logic [31:0] if_data_o;
`ifdef MEM_CTRL_IF_ABORT_EN
    logic        if_flush_i;
`endif

    // MEM stage side
    logic        mem_req_i;
    logic        mem_wr_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;

    // RAM pins
    logic [7:0]  ram_din_i;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;

`ifdef MEM_CTRL_IF_ABORT_EN
    // Requesters and RAM model
    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output mem_req_i, mem_wr_i, mem_len_i, mem_addr_i, mem_wdata_i,
        output ram_din_i,
        input  if_done_o, if_data_o, mem_done_o, mem_rdata_o,
        input  ram_a_o, ram_wr_o, ram_dout_o
    );

    // Controller
    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  mem_req_i, mem_wr_i, mem_len_i, mem_addr_i, mem_wdata_i,
        input  ram_din_i,
        output if_done_o, if_data_o, mem_done_o, mem_rdata_o,
        output ram_a_o, ram_wr_o, ram_dout_o
    );
`else
    // Requesters and RAM model
    modport master (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_wr_i, mem_len_i, mem_addr_i, mem_wdata_i,
        output ram_din_i,
        input  if_done_o, if_data_o, mem_done_o, mem_rdata_o,
        input  ram_a_o, ram_wr_o, ram_dout_o
    );

    // Controller
    modport slave (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_wr_i, mem_len_i, mem_addr_i, mem_wdata_i,
        input  ram_din_i,
        output if_done_o, if_data_o, mem_done_o, mem_rdata_o,
        output ram_a_o, ram_wr_o, ram_dout_o
    );
`endif

endinterface

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: combinational fixed-priority select between MEM and IF.
// MEM always wins; IF is masked by flush; nothing is granted outside IDLE
// or during the done/turnaround cycle.
module mem_ctrl_arb (
    input  logic idle,
    input  logic turnaround,
    input  logic if_req,
    input  logic mem_req,
    input  logic if_flush,
    output logic grant_if,
    output logic grant_mem
);

    // Priority select: MEM first, then an unflushed IF request
    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (idle && !turnaround) begin
            if (mem_req) begin
                grant_mem = 1'b1;
            end else if (if_req && !if_flush) begin
                grant_if = 1'b1;
            end else begin
                grant_if  = 1'b0;
                grant_mem = 1'b0;
            end
        end else begin
            grant_if  = 1'b0;
            grant_mem = 1'b0;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide synchronous RAM port between instruction
// fetch and the MEM stage. Each request becomes 1, 2 or 4 byte cycles;
// read bytes are assembled little-endian and a one-cycle done is returned.
// Optional fetch abort: define MEM_CTRL_IF_ABORT_EN to add if_flush_i.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    mc_state_e   state_r;
    logic [2:0]  cnt_r;
    logic [2:0]  len_r;
    logic [31:0] wdata_r;
    logic [31:0] rbuf_r;
    logic [31:0] ram_a_r;
    logic        ram_wr_r;
    logic [7:0]  ram_dout_r;
    logic        if_done_r;
    logic        mem_done_r;
    logic [31:0] if_data_r;
    logic [31:0] mem_rdata_r;

    logic        flush_s;
    logic        idle_s;
    logic        turnaround_s;
    logic        grant_if_s;
    logic        grant_mem_s;
    logic [2:0]  cnt_inc_s;
    logic [1:0]  cap_idx_s;
    logic        rd_issue_s;
    logic        rd_last_s;
    logic        wr_last_s;
    logic [31:0] rd_merge_s;

`ifdef MEM_CTRL_IF_ABORT_EN
    assign flush_s = bus.if_flush_i;
`else
    assign flush_s = 1'b0;
`endif

    assign idle_s       = (state_r == MC_IDLE);
    assign turnaround_s = if_done_r | mem_done_r;

    mem_ctrl_arb u_arb (
        .idle       (idle_s),
        .turnaround (turnaround_s),
        .if_req     (bus.if_req_i),
        .mem_req    (bus.mem_req_i),
        .if_flush   (flush_s),
        .grant_if   (grant_if_s),
        .grant_mem  (grant_mem_s)
    );

    // Byte bookkeeping: cnt_r counts edges since the grant edge minus one.
    // On a read, byte (cnt_r-1) arrives on ram_din_i and the transfer ends
    // when cnt_r reaches the length; on a write it ends when cnt_r+1 does.
    always_comb begin
        cnt_inc_s  = cnt_r + 3'd1;
        cap_idx_s  = cnt_r[1:0] - 2'd1;
        rd_issue_s = (cnt_inc_s < len_r);
        rd_last_s  = (cnt_r == len_r);
        wr_last_s  = (cnt_inc_s == len_r);
        rd_merge_s = mc_put_byte(rbuf_r, cap_idx_s, bus.ram_din_i);
    end

    // Main controller FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= MC_IDLE;
            cnt_r       <= 3'd0;
            len_r       <= 3'd0;
            wdata_r     <= ZeroWord;
            rbuf_r      <= ZeroWord;
            ram_a_r     <= ZeroWord;
            ram_wr_r    <= WriteDisable;
            ram_dout_r  <= Zero8;
            if_done_r   <= 1'b0;
            mem_done_r  <= 1'b0;
            if_data_r   <= ZeroWord;
            mem_rdata_r <= ZeroWord;
        end else begin
            if_done_r  <= 1'b0;
            mem_done_r <= 1'b0;
            case (state_r)
                MC_IDLE: begin
                    cnt_r      <= 3'd0;
                    ram_a_r    <= ZeroWord;
                    ram_wr_r   <= WriteDisable;
                    ram_dout_r <= Zero8;
                    if (grant_mem_s) begin
                        len_r   <= mc_len_bytes(bus.mem_len_i);
                        wdata_r <= bus.mem_wdata_i;
                        rbuf_r  <= ZeroWord;
                        ram_a_r <= bus.mem_addr_i;
                        if (bus.mem_wr_i) begin
                            state_r    <= MC_MEM_WR;
                            ram_wr_r   <= WriteEnable;
                            ram_dout_r <= bus.mem_wdata_i[7:0];
                        end else begin
                            state_r <= MC_MEM_RD;
                        end
                    end else if (grant_if_s) begin
                        len_r   <= 3'd4;
                        rbuf_r  <= ZeroWord;
                        ram_a_r <= bus.if_addr_i;
                        state_r <= MC_IF_RD;
                    end else begin
                        state_r <= MC_IDLE;
                    end
                end

                MC_IF_RD, MC_MEM_RD: begin
                    if ((state_r == MC_IF_RD) && flush_s) begin
                        // Aborted fetch: no done, fetched data left untouched
                        state_r <= MC_IDLE;
                        cnt_r   <= 3'd0;
                        ram_a_r <= ZeroWord;
                    end else if (rd_last_s) begin
                        state_r <= MC_IDLE;
                        cnt_r   <= 3'd0;
                        ram_a_r <= ZeroWord;
                        if (state_r == MC_IF_RD) begin
                            if_data_r <= rd_merge_s;
                            if_done_r <= 1'b1;
                        end else begin
                            mem_rdata_r <= rd_merge_s;
                            mem_done_r  <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_inc_s;
                        if (cnt_r != 3'd0) begin
                            rbuf_r <= rd_merge_s;
                        end else begin
                            rbuf_r <= rbuf_r;
                        end
                        if (rd_issue_s) begin
                            ram_a_r <= ram_a_r + 32'd1;
                        end else begin
                            ram_a_r <= ram_a_r;
                        end
                    end
                end

                MC_MEM_WR: begin
                    if (wr_last_s) begin
                        state_r    <= MC_IDLE;
                        cnt_r      <= 3'd0;
                        ram_a_r    <= ZeroWord;
                        ram_wr_r   <= WriteDisable;
                        ram_dout_r <= Zero8;
                        mem_done_r <= 1'b1;
                    end else begin
                        cnt_r      <= cnt_inc_s;
                        ram_a_r    <= ram_a_r + 32'd1;
                        ram_wr_r   <= WriteEnable;
                        ram_dout_r <= mc_get_byte(wdata_r, cnt_inc_s[1:0]);
                    end
                end

                default: begin
                    state_r    <= MC_IDLE;
                    cnt_r      <= 3'd0;
                    ram_a_r    <= ZeroWord;
                    ram_wr_r   <= WriteDisable;
                    ram_dout_r <= Zero8;
                end
            endcase
        end
    end

    assign bus.ram_a_o     = ram_a_r;
    assign bus.ram_wr_o    = ram_wr_r;
    assign bus.ram_dout_o  = ram_dout_r;
    assign bus.if_done_o   = if_done_r;
    assign bus.if_data_o   = if_data_r;
    assign bus.mem_done_o  = mem_done_r;
    assign bus.mem_rdata_o = mem_rdata_r;

endmodule
